// File: rtl/iiitb_rv32i_mem_arb_if.sv
// Bus bundle between the rv32i pipeline ports (IF/DM), the arbiter and the
// unified single-port memory macro. The slave view belongs to the arbiter.
interface iiitb_rv32i_mem_arb_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/iiitb_rv32i_mem_arb.sv
// Fetch/data arbiter in front of a single-port unified memory with a fixed
// read latency of MEM_LAT cycles. Grants are combinational in IDLE; a read
// parks the FSM in WAIT until the data has been captured for its owner.
// Default policy: DM priority, IF overrides after STARVE_MAX waiting cycles.
// Optional IIITB_ARB_RR_EN: plain round-robin on contention, no starve counter.
module iiitb_rv32i_mem_arb #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        RN,
    iiitb_rv32i_mem_arb_if.slave        bus,
    output logic                        busy
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_lat_cnt;
    logic       r_owner_dm;
    logic       r_if_rvalid, r_dm_rvalid;
    logic [$bits(bus.if_rdata)-1:0] r_if_rdata, r_dm_rdata;

    logic w_grant_ok, w_pick_dm, w_if_gnt, w_dm_gnt, w_rd_grant, w_last_beat;

    assign w_grant_ok  = !RN && (r_state == S_IDLE);
    assign w_dm_gnt    = w_grant_ok && w_pick_dm;
    assign w_if_gnt    = w_grant_ok && bus.if_req && !w_pick_dm;
    assign w_rd_grant  = w_if_gnt || (w_dm_gnt && !bus.dm_we);
    assign w_last_beat = (r_state == S_WAIT) && (r_lat_cnt == 3'd1);

`ifdef IIITB_ARB_RR_EN
    logic r_last_dm;

    // Round-robin pick: on contention the port not served last wins
    always_comb begin
        w_pick_dm = bus.dm_req && (!bus.if_req || !r_last_dm);
    end

    // Remember who was granted most recently (reset as if IF went last)
    always_ff @(posedge clk) begin
        if (RN)                        r_last_dm <= 1'b0;
        else if (w_if_gnt || w_dm_gnt) r_last_dm <= w_dm_gnt;
    end
`else
    logic [3:0] r_starve_cnt;

    // DM wins unless a waiting fetch has been starved long enough
    always_comb begin
        w_pick_dm = bus.dm_req && !(bus.if_req && (r_starve_cnt >= 4'(STARVE_MAX)));
    end

    // Count cycles a fetch sits unserved, saturating; cleared when it gets in
    always_ff @(posedge clk) begin
        if (RN)                                          r_starve_cnt <= 4'd0;
        else if (w_if_gnt)                               r_starve_cnt <= 4'd0;
        else if (bus.if_req && r_starve_cnt != 4'd15)    r_starve_cnt <= r_starve_cnt + 4'd1;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (RN) r_state <= S_IDLE;
        else    r_state <= w_state_nxt;
    end

    // Next state: reads park in WAIT, stores complete in the grant cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_rd_grant)  w_state_nxt = S_WAIT;
            S_WAIT: if (w_last_beat) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: grants and memory strobe muxed from the winner, zero when idle
    always_comb begin
        bus.if_gnt    = w_if_gnt;
        bus.dm_gnt    = w_dm_gnt;
        bus.mem_en    = w_if_gnt || w_dm_gnt;
        bus.mem_we    = w_dm_gnt && bus.dm_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (w_dm_gnt) begin
            bus.mem_addr = bus.dm_addr;
            if (bus.dm_we) bus.mem_wdata = bus.dm_wdata;
        end else if (w_if_gnt) begin
            bus.mem_addr = bus.if_addr;
        end
        bus.if_rvalid = r_if_rvalid;
        bus.dm_rvalid = r_dm_rvalid;
        bus.if_rdata  = r_if_rdata;
        bus.dm_rdata  = r_dm_rdata;
        busy          = (r_state != S_IDLE);
    end

    // Latency counter and read owner, loaded on each read grant
    always_ff @(posedge clk) begin
        if (RN) begin
            r_lat_cnt  <= 3'd0;
            r_owner_dm <= 1'b0;
        end else if (w_rd_grant) begin
            r_lat_cnt  <= 3'(MEM_LAT);
            r_owner_dm <= w_dm_gnt;
        end else if (r_state == S_WAIT) begin
            r_lat_cnt  <= r_lat_cnt - 3'd1;
        end
    end

    // Capture read data for the owner on the last wait beat; rvalid is a pulse
    always_ff @(posedge clk) begin
        if (RN) begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_last_beat && !r_owner_dm;
            r_dm_rvalid <= w_last_beat && r_owner_dm;
            if (w_last_beat && !r_owner_dm) r_if_rdata <= bus.mem_rdata;
            if (w_last_beat && r_owner_dm)  r_dm_rdata <= bus.mem_rdata;
        end
    end
endmodule
